// File: rtl/dual_port_ram_ctl.sv
// rtl/dual_port_ram_ctl.sv - true dual-port synchronous RAM with collision arbitration and clear engine
module dual_port_ram_ctl #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 10,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] out_a,
   input  logic                  en_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic [DATA_WIDTH-1:0] out_b,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  collision
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_addr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    start_clear;
   logic                    user_ok;
   logic                    same_addr;
   logic                    wr_a;
   logic                    wr_b_req;
   logic                    wr_b;
   logic                    coll_now;
   logic [DATA_WIDTH-1:0]   new_a;
   logic [DATA_WIDTH-1:0]   new_b;
   logic [DATA_WIDTH-1:0]   rdata_a;
   logic [DATA_WIDTH-1:0]   rdata_b;

   // Access qualification, port A priority on same-address writes, read-during-write data selection
   always_comb begin
      start_clear = (state == ST_IDLE) && clear_req;
      // The cycle that accepts a clear request already behaves like a clear cycle for users
      user_ok     = reset_n && (state == ST_IDLE) && !clear_req;
      same_addr   = (addr_a == addr_b);
      wr_a        = user_ok && en_a && we_a;
      wr_b_req    = user_ok && en_b && we_b;
      coll_now    = wr_a && wr_b_req && same_addr;
      wr_b        = wr_b_req && !coll_now;

      new_a = mem[addr_a];
      if (wr_a) begin
         new_a = data_a;
      end else if (wr_b && same_addr) begin
         new_a = data_b;
      end

      new_b = mem[addr_b];
      if (wr_a && same_addr) begin
         new_b = data_a;
      end else if (wr_b) begin
         new_b = data_b;
      end

      rdata_a = (RDW_MODE != 0) ? new_a : mem[addr_a];
      rdata_b = (RDW_MODE != 0) ? new_b : mem[addr_b];
   end

   // Clear engine FSM: sweeps every address once, then returns to idle with the sweep address wrapped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         busy     <= (CLEAR_ON_RESET != 0);
         clr_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_clear) begin
                  state <= ST_CLEAR;
                  busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  clr_addr <= '0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Array writes: the clear sweep owns the array while active, otherwise the qualified user writes
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
         end else begin
            if (wr_a) begin
               mem[addr_a] <= data_a;
            end
            if (wr_b) begin
               mem[addr_b] <= data_b;
            end
         end
      end
   end

   // Registered read data and collision pulse; outputs forced to zero whenever users are locked out
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_a     <= '0;
         out_b     <= '0;
         collision <= 1'b0;
      end else begin
         collision <= coll_now;
         if (!user_ok) begin
            out_a <= '0;
            out_b <= '0;
         end else begin
            if (en_a) begin
               out_a <= rdata_a;
            end
            if (en_b) begin
               out_b <= rdata_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_dual_port_ram_ctl.sv
// tb/tb_dual_port_ram_ctl.sv - scoreboard bench for dual_port_ram_ctl in both read-during-write modes
module tb_dual_port_ram_ctl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
   logic [9:0]  addr_a = '0, addr_b = '0;
   logic [15:0] data_a = '0, data_b = '0;
   logic        clear_req = 1'b0;

   logic [15:0] out_a0, out_b0, out_a1, out_b1;
   logic        busy0, busy1, coll0, coll1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] a0;
      logic [15:0] b0;
      logic [15:0] a1;
      logic [15:0] b1;
      logic        coll;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mdl [1024];
   logic [15:0] la0, lb0, la1, lb1;

   dual_port_ram_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .out_a(out_a0),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .out_b(out_b0),
      .clear_req(clear_req), .busy(busy0), .collision(coll0)
   );

   dual_port_ram_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .out_a(out_a1),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .out_b(out_b1),
      .clear_req(clear_req), .busy(busy1), .collision(coll1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model after a full clear: array and both read registers are zero
   task automatic model_clear();
      for (int i = 0; i < 1024; i++) mdl[i] = 16'h0000;
      la0 = 0; lb0 = 0; la1 = 0; lb1 = 0;
   endtask

   // One user cycle: drive at negedge, predict with read-before-write (mode 0) and read-after-write (mode 1)
   task automatic op(input logic ea, input logic wa, input logic [9:0] aa, input logic [15:0] da,
                     input logic eb, input logic wb, input logic [9:0] ab, input logic [15:0] db);
      exp_t        e;
      logic        wra, wrb, col;
      logic [15:0] old_a, old_b;
      @(negedge clk);
      en_a = ea; we_a = wa; addr_a = aa; data_a = da;
      en_b = eb; we_b = wb; addr_b = ab; data_b = db;
      wra   = ea & wa;
      wrb   = eb & wb;
      col   = wra & wrb & (aa == ab);
      old_a = mdl[aa];
      old_b = mdl[ab];
      if (wrb && !col) mdl[ab] = db;
      if (wra) mdl[aa] = da;
      if (ea) begin la0 = old_a; la1 = mdl[aa]; end
      if (eb) begin lb0 = old_b; lb1 = mdl[ab]; end
      e.a0 = la0; e.b0 = lb0; e.a1 = la1; e.b1 = lb1; e.coll = col;
      sb_q.push_back(e);
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      en_a = 0; we_a = 0; en_b = 0; we_b = 0;
   endtask

   // Counts cycles each instance spends busy, starting with busy already high
   task automatic wait_clear(input string nm);
      int c0 = 0, c1 = 0, guard = 0;
      while ((busy0 || busy1) && guard < 3000) begin
         if (busy0) c0++;
         if (busy1) c1++;
         @(posedge clk);
         #1;
         guard++;
      end
      chk({nm, "_busy_cycles_m0"}, c0, 1024);
      chk({nm, "_busy_cycles_m1"}, c1, 1024);
      model_clear();
   endtask

   // Monitor: pops one expectation per clock and compares both instances
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_a_m0", out_a0, e.a0);
            chk("out_b_m0", out_b0, e.b0);
            chk("out_a_m1", out_a1, e.a1);
            chk("out_b_m1", out_b1, e.b1);
            chk("coll_m0", coll0, e.coll);
            chk("coll_m1", coll1, e.coll);
            chk("busy_idle", {busy1, busy0}, 2'b00);
         end
      end
   end

   initial begin
      logic [9:0] ra, rb;
      int         guard;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_a", {out_a1, out_a0}, 32'h0);
      chk("rst_out_b", {out_b1, out_b0}, 32'h0);
      chk("rst_coll", {coll1, coll0}, 2'b00);
      chk("rst_busy", {busy1, busy0}, 2'b11);

      // Power-on clear
      @(negedge clk);
      reset_n = 1;
      wait_clear("por");
      op(1, 0, 10'h3FF, 16'h0, 1, 0, 10'h3FF, 16'h0);

      // Independent writes then reads
      op(1, 1, 10'h000, 16'hFEFE, 1, 1, 10'h001, 16'hEFEF);
      op(1, 0, 10'h000, 16'h0, 1, 0, 10'h001, 16'h0);

      // Same-address dual write, port A wins
      op(1, 1, 10'h002, 16'hBEAF, 1, 1, 10'h002, 16'hDEAD);
      op(0, 0, 10'h000, 16'h0, 0, 0, 10'h000, 16'h0);
      op(1, 0, 10'h002, 16'h0, 1, 0, 10'h002, 16'h0);

      // Cross-port read-during-write
      op(1, 1, 10'h005, 16'h1111, 0, 0, 10'h000, 16'h0);
      op(1, 1, 10'h005, 16'h2222, 1, 0, 10'h005, 16'h0);
      op(0, 0, 10'h000, 16'h0, 1, 0, 10'h005, 16'h0);

      // Disabled port with write enable set
      op(1, 0, 10'h001, 16'h0, 0, 0, 10'h000, 16'h0);
      op(0, 1, 10'h010, 16'hABCD, 0, 0, 10'h000, 16'h0);
      op(1, 0, 10'h001, 16'h0, 1, 0, 10'h010, 16'h0);

      // Randomized traffic, narrow address window to provoke collisions
      for (int i = 0; i < 1500; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
         rb = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
         op($urandom_range(0, 3) != 0, 1'($urandom), ra, 16'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), rb, 16'($urandom));
      end
      op(1, 0, 10'h003, 16'h0, 1, 0, 10'h004, 16'h0);
      idle_inputs();

      // Requested clear, interrupted by reset at clear cycle 300
      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      clear_req = 1;
      @(negedge clk);
      clear_req = 0;
      repeat (149) @(negedge clk);
      chk("mid_clear_busy", {busy1, busy0}, 2'b11);
      chk("mid_clear_out", {out_a1, out_b1, out_a0, out_b0}, 64'h0);
      repeat (150) @(negedge clk);
      reset_n = 0;
      #1;
      chk("rst2_out", {out_a1, out_b1, out_a0, out_b0}, 64'h0);
      chk("rst2_busy", {busy1, busy0}, 2'b11);
      repeat (2) @(negedge clk);
      reset_n = 1;
      wait_clear("restart");
      op(1, 0, 10'h002, 16'h0, 1, 0, 10'h3FF, 16'h0);
      op(1, 1, 10'h3FF, 16'h5A5A, 1, 0, 10'h3FF, 16'h0);
      op(1, 0, 10'h3FF, 16'h0, 0, 0, 10'h000, 16'h0);
      idle_inputs();

      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      @(posedge clk);
      #2;
      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
